// File: rtl/instr_prefetch_queue.sv
// Prefetch FIFO between fetch and the decode pipeline register.
// Each entry holds {pc, instr}; the head is visible combinationally, and a flush discards every entry.
module instr_prefetch_queue #(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       f_valid,
  input  logic [PC_WIDTH-1:0]        f_pc,
  input  logic [INSTR_WIDTH-1:0]     f_instr,
  output logic                       f_ready,
  output logic                       d_valid,
  output logic [PC_WIDTH-1:0]        d_pc,
  output logic [INSTR_WIDTH-1:0]     d_instr,
  input  logic                       d_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic                   push;
  logic                   pop;

  // f_ready looks only at registered occupancy and flush, so a push is refused while
  // full even when decode pops in the same cycle.
  assign f_ready = (count < FULL_COUNT) & ~flush;
  assign d_valid = (count != '0);
  assign push    = f_valid & f_ready;
  assign pop     = d_valid & d_ready & ~flush;

  assign d_pc    = d_valid ? pc_mem[rd_ptr]    : '0;
  assign d_instr = d_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is; count==0 hides the stale contents.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= f_pc;
        instr_mem[wr_ptr] <= f_instr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: an expected {pc,instr} is queued when a push is
// driven, and popped and compared when decode consumes the head.
module tb_instr_prefetch_queue;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       f_valid;
  logic [7:0] f_pc;
  logic [7:0] f_instr;
  logic       f_ready;
  logic       d_valid;
  logic [7:0] d_pc;
  logic [7:0] d_instr;
  logic       d_ready;
  logic       flush;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(4), .PC_WIDTH(8), .INSTR_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_ready(d_ready),
    .flush(flush), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle; outputs are compared on the falling edge, the model advances after the rising edge.
  task automatic cycle(input logic fv, input logic [7:0] pc, input logic [7:0] ins,
                       input logic dr, input logic fl);
    logic exp_push, exp_pop;
    f_valid = fv; f_pc = pc; f_instr = ins; d_ready = dr; flush = fl;
    @(negedge clk);
    check("count", 32'(count), 32'(sb.size()));
    check("d_valid", 32'(d_valid), 32'(sb.size() != 0));
    check("f_ready", 32'(f_ready), 32'(sb.size() < 4 && !fl));
    if (sb.size() != 0) begin
      check("head_pc", 32'(d_pc), 32'(sb[0][15:8]));
      check("head_instr", 32'(d_instr), 32'(sb[0][7:0]));
    end else begin
      check("empty_pc", 32'(d_pc), 32'h0);
      check("empty_instr", 32'(d_instr), 32'h0);
    end
    exp_push = fv && (sb.size() < 4) && !fl;
    exp_pop  = dr && (sb.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back({pc, ins});
    end
    f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] pc, input logic [7:0] ins);
    cycle(1'b1, pc, ins, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) pop_one();
  endtask

  initial begin
    n_rst = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; d_ready = 1'b0; flush = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_f_ready", 32'(f_ready), 32'h1);
    check("rst_d_valid", 32'(d_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // fill / drain, including a push attempt while full
    for (int i = 0; i < 4; i++) push_one(8'(8'h10 + i), 8'(8'hA0 + i));
    push_one(8'h99, 8'h99);
    drain();

    // wrap across the pointer boundary
    for (int i = 0; i < 3; i++) push_one(8'(8'h20 + i), 8'(8'hB0 + i));
    pop_one(); pop_one();
    for (int i = 0; i < 4; i++) push_one(8'(8'h28 + i), 8'(8'hB8 + i));
    drain();

    // simultaneous push+pop at count 2, then at full
    push_one(8'h30, 8'hC0); push_one(8'h31, 8'hC1);
    cycle(1'b1, 8'h32, 8'hC2, 1'b1, 1'b0);
    push_one(8'h33, 8'hC3); push_one(8'h34, 8'hC4);
    cycle(1'b1, 8'h35, 8'hC5, 1'b1, 1'b0);
    drain();

    // flush with count 3 and coincident handshakes, then refill
    for (int i = 0; i < 3; i++) push_one(8'(8'h38 + i), 8'(8'hD0 + i));
    cycle(1'b1, 8'h3F, 8'hDF, 1'b1, 1'b1);
    push_one(8'h40, 8'hE0);
    pop_one();
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // asynchronous reset between edges with count 2
    push_one(8'h50, 8'hF0); push_one(8'h51, 8'hF1);
    #2 n_rst = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_d_valid", 32'(d_valid), 32'h0);
    check("async_f_ready", 32'(f_ready), 32'h1);
    check("async_d_pc", 32'(d_pc), 32'h0);
    check("async_d_instr", 32'(d_instr), 32'h0);
    sb.delete();
    #3 n_rst = 1'b1;
    @(posedge clk); #1;
    push_one(8'h60, 8'h66);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
